decoder_bank: RTL and testbench



---
 rtl/decoder_pkg.sv | 13 +
 rtl/decoder_1_to_2.sv | 12 +
 rtl/decoder_2_to_4.sv | 31 +++
 rtl/decoder_3_to_8.sv | 30 +++
 rtl/decoder_bank.sv | 87 ++++++++
 tb/tb_decoder_bank.sv | 134 +++++++++++++
 6 files changed

// File: rtl/decoder_pkg.sv
// Shared widths and one-hot vector types for the decoder bank.
package decoder_pkg;

    localparam int unsigned DEC1_W = 2;
    localparam int unsigned DEC2_W = 4;
    localparam int unsigned DEC3_W = 8;
    localparam int unsigned SEL_W  = 3;

    typedef logic [DEC1_W-1:0] dec2_t;
    typedef logic [DEC2_W-1:0] dec4_t;
    typedef logic [DEC3_W-1:0] dec8_t;

endpackage

// File: rtl/decoder_1_to_2.sv
// Combinational 1:2 leaf decoder; both lines are 0 when ena_i is low.
module decoder_1_to_2
    import decoder_pkg::*;
(
    input  logic  ena_i,
    input  logic  in_i,
    output dec2_t out_o
);

    assign out_o = {ena_i & in_i, ena_i & ~in_i};

endmodule

// File: rtl/decoder_2_to_4.sv
// Combinational 2:4 decoder built from three 1:2 leaves.
module decoder_2_to_4
    import decoder_pkg::*;
(
    input  logic       ena_i,
    input  logic [1:0] in_i,
    output dec4_t      out_o
);

    dec2_t hi_sel;

    // The upper select bit picks which lower leaf is enabled.
    decoder_1_to_2 u_hi (
        .ena_i (ena_i),
        .in_i  (in_i[1]),
        .out_o (hi_sel)
    );

    decoder_1_to_2 u_lo0 (
        .ena_i (hi_sel[0]),
        .in_i  (in_i[0]),
        .out_o (out_o[1:0])
    );

    decoder_1_to_2 u_lo1 (
        .ena_i (hi_sel[1]),
        .in_i  (in_i[0]),
        .out_o (out_o[3:2])
    );

endmodule

// File: rtl/decoder_3_to_8.sv
// Combinational 3:8 decoder built from a 1:2 leaf and two 2:4 decoders.
module decoder_3_to_8
    import decoder_pkg::*;
(
    input  logic             ena_i,
    input  logic [SEL_W-1:0] in_i,
    output dec8_t            out_o
);

    dec2_t hi_sel;

    decoder_1_to_2 u_hi (
        .ena_i (ena_i),
        .in_i  (in_i[2]),
        .out_o (hi_sel)
    );

    decoder_2_to_4 u_lo0 (
        .ena_i (hi_sel[0]),
        .in_i  (in_i[1:0]),
        .out_o (out_o[3:0])
    );

    decoder_2_to_4 u_lo1 (
        .ena_i (hi_sel[1]),
        .in_i  (in_i[1:0]),
        .out_o (out_o[7:4])
    );

endmodule

// File: rtl/decoder_bank.sv
// Registered bank of 1:2, 2:4 and 3:8 decoders on a shared enable/select.
// Optional simulation-only one-hot checking with DECODER_BANK_ONEHOT_CHECK_EN.
module decoder_bank
    import decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [SEL_W-1:0] in,
    output dec2_t            out2,
    output dec4_t            out4,
    output dec8_t            out8
);

    dec2_t dec2_comb;
    dec4_t dec4_comb;
    dec8_t dec8_comb;
    dec2_t out2_d, out2_q;
    dec4_t out4_d, out4_q;
    dec8_t out8_d, out8_q;

    decoder_1_to_2 u_dec1 (
        .ena_i (ena),
        .in_i  (in[0]),
        .out_o (dec2_comb)
    );

    decoder_2_to_4 u_dec2 (
        .ena_i (ena),
        .in_i  (in[1:0]),
        .out_o (dec4_comb)
    );

    decoder_3_to_8 u_dec3 (
        .ena_i (ena),
        .in_i  (in),
        .out_o (dec8_comb)
    );

    always_comb begin
        out2_d = dec2_comb;
        out4_d = dec4_comb;
        out8_d = dec8_comb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out2_q <= '0;
            out4_q <= '0;
            out8_q <= '0;
        end else begin
            out2_q <= out2_d;
            out4_q <= out4_d;
            out8_q <= out8_d;
        end
    end

    assign out2 = out2_q;
    assign out4 = out4_q;
    assign out8 = out8_q;

`ifdef DECODER_BANK_ONEHOT_CHECK_EN
    logic             chk_ena_q;
    logic [SEL_W-1:0] chk_in_q;

    // Outputs read here are the pre-edge values, i.e. the decode of chk_ena_q/chk_in_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_ena_q <= 1'b0;
            chk_in_q  <= '0;
        end else begin
            chk_ena_q <= ena;
            chk_in_q  <= in;
            if (chk_ena_q) begin
                assert ($onehot(out2_q)) else $error("out2 not one-hot, in=%0d", chk_in_q);
                assert ($onehot(out4_q)) else $error("out4 not one-hot, in=%0d", chk_in_q);
                assert ($onehot(out8_q)) else $error("out8 not one-hot, in=%0d", chk_in_q);
            end else begin
                assert (out2_q == '0) else $error("out2 not zero, in=%0d", chk_in_q);
                assert (out4_q == '0) else $error("out4 not zero, in=%0d", chk_in_q);
                assert (out8_q == '0) else $error("out8 not zero, in=%0d", chk_in_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_decoder_bank.sv
// Self-checking bench for decoder_bank against a shift-based reference model.
module tb_decoder_bank;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [2:0] in;
    logic [1:0] out2;
    logic [3:0] out4;
    logic [7:0] out8;

    int total;
    int bad;

    logic [1:0] exp2;
    logic [3:0] exp4;
    logic [7:0] exp8;

    decoder_bank dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .in    (in),
        .out2  (out2),
        .out4  (out4),
        .out8  (out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
        total++;
        assert (obs === want)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out2"}, {6'd0, out2}, {6'd0, exp2});
        check({tag, ".out4"}, {4'd0, out4}, {4'd0, exp4});
        check({tag, ".out8"}, out8, exp8);
    endtask

    // Reference: line number equals the select field, everything 0 when disabled.
    task automatic model(input logic e, input logic [2:0] s);
        int unsigned v;
        v = s;
        exp2 = e ? 2'(1 << (v % 2)) : 2'd0;
        exp4 = e ? 4'(1 << (v % 4)) : 4'd0;
        exp8 = e ? 8'(1 << v) : 8'd0;
    endtask

    // Drive away from the edge, confirm outputs hold until the edge, then check the new decode.
    task automatic step(input string tag, input logic e, input logic [2:0] s);
        @(negedge clk);
        ena = e;
        in  = s;
        #1;
        check_all({tag, ".hold"});
        @(posedge clk);
        #1;
        model(e, s);
        check_all(tag);
        check({tag, ".parity"}, {7'd0, out2[1]}, {7'd0, |(out4 & 4'b1010)});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        ena   = 1'b1;
        in    = 3'b111;
        exp2  = '0;
        exp4  = '0;
        exp8  = '0;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model(1'b1, 3'b111);
        check({"release.out2"}, {6'd0, out2}, 8'h02);
        check({"release.out4"}, {4'd0, out4}, 8'h08);
        check({"release.out8"}, out8, 8'h80);

        for (int i = 0; i < 8; i++) step($sformatf("en_sweep%0d", i), 1'b1, 3'(i));
        for (int i = 0; i < 8; i++) step($sformatf("dis_sweep%0d", i), 1'b0, 3'(i));

        step("lat3", 1'b1, 3'd3);
        check("lat3.val", out8, 8'h08);
        step("lat6", 1'b1, 3'd6);
        check("lat6.val", out8, 8'h40);

        step("ex5", 1'b1, 3'd5);
        check("ex5.out4", {4'd0, out4}, 8'h02);
        check("ex5.out8", out8, 8'h20);

        step("async_pre", 1'b1, 3'd4);
        check("async_pre.val", out8, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        exp2 = '0;
        exp4 = '0;
        exp8 = '0;
        check_all("async_low");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("async_rel.out8", out8, 8'h10);
        model(1'b1, 3'd4);

        step("drop_pre", 1'b1, 3'd7);
        check("drop_pre.val", out8, 8'h80);
        step("drop", 1'b0, 3'd7);
        check("drop.val", out8, 8'h00);

        for (int i = 0; i < 40; i++) begin
            step($sformatf("rand%0d", i), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
